// File: rtl/nios2_mul_seq_ctrl.sv
// nios2_mul_seq_ctrl
//   Sequences one registered HALF x HALF unsigned multiplier to build a full
//   WIDTH x WIDTH -> 2*WIDTH product. Signed operands go through a magnitude
//   stage on accept and a conditional negate before the result is presented.
//   One operation in flight; valid/ready handshakes on both request and result.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   in_valid    request valid
//   in_ready    controller idle and able to accept a request
//   in_a/in_b   operands
//   in_sign_a/b operand is two's complement
//   in_lo_only  only the low WIDTH bits of the product are needed
//   out_valid   result valid, held until accepted
//   out_ready   consumer accepts result
//   out_result  2*WIDTH-bit product
//
// Parameters
//   WIDTH    operand width, must be even
//   LO_SKIP  1: lo_only requests skip the high*high partial product

module nios2_mul_seq_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter bit          LO_SKIP = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_sign_a,
  input  logic               in_sign_b,
  input  logic               in_lo_only,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned RW   = 2 * WIDTH;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_DRAIN = 3'd2;
  localparam logic [2:0] ST_FIX   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Partial product indices, in issue order.
  localparam logic [1:0] P_LL = 2'd0; // AL*BL, weight 0
  localparam logic [1:0] P_HL = 2'd1; // AH*BL, weight HALF
  localparam logic [1:0] P_LH = 2'd2; // AL*BH, weight HALF
  localparam logic [1:0] P_HH = 2'd3; // AH*BH, weight WIDTH

  logic [2:0]       state_q, state_d;
  logic [WIDTH-1:0] a_mag_q, a_mag_d;
  logic [WIDTH-1:0] b_mag_q, b_mag_d;
  logic             neg_q, neg_d;
  logic             lo_only_q, lo_only_d;
  logic [1:0]       idx_q, idx_d;
  logic [RW-1:0]    acc_q, acc_d;
  logic [RW-1:0]    result_q, result_d;

  // Multiplier pipeline register plus the tag saying which partial it holds.
  logic [WIDTH-1:0] prod_q, prod_d;
  logic             prod_vld_q, prod_vld_d;
  logic [1:0]       prod_idx_q, prod_idx_d;

  logic [HALF-1:0]  mul_a, mul_b;
  logic [RW-1:0]    prod_ext;
  logic [RW-1:0]    prod_shifted;
  logic [1:0]       last_idx;
  logic             sa, sb;

  // Only a set sign bit on a signed operand counts as negative.
  assign sa = in_sign_a & in_a[WIDTH-1];
  assign sb = in_sign_b & in_b[WIDTH-1];

  // The high*high partial only affects bits >= WIDTH, so lo_only may drop it.
  assign last_idx = (lo_only_q && LO_SKIP) ? P_LH : P_HH;

  // Operand halves steered to the multiplier for the partial being issued.
  always_comb begin
    mul_a = a_mag_q[HALF-1:0];
    mul_b = b_mag_q[HALF-1:0];
    unique case (idx_q)
      P_LL: begin
        mul_a = a_mag_q[HALF-1:0];
        mul_b = b_mag_q[HALF-1:0];
      end
      P_HL: begin
        mul_a = a_mag_q[WIDTH-1:HALF];
        mul_b = b_mag_q[HALF-1:0];
      end
      P_LH: begin
        mul_a = a_mag_q[HALF-1:0];
        mul_b = b_mag_q[WIDTH-1:HALF];
      end
      P_HH: begin
        mul_a = a_mag_q[WIDTH-1:HALF];
        mul_b = b_mag_q[WIDTH-1:HALF];
      end
    endcase
  end

  // Registered multiplier: product available one cycle after issue.
  always_comb begin
    prod_d = WIDTH'(mul_a) * WIDTH'(mul_b);
  end

  // Align the returning partial to its weight before accumulation.
  always_comb begin
    prod_ext     = {{WIDTH{1'b0}}, prod_q};
    prod_shifted = prod_ext;
    unique case (prod_idx_q)
      P_LL:       prod_shifted = prod_ext;
      P_HL, P_LH: prod_shifted = prod_ext << HALF;
      P_HH:       prod_shifted = prod_ext << WIDTH;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    a_mag_d    = a_mag_q;
    b_mag_d    = b_mag_q;
    neg_d      = neg_q;
    lo_only_d  = lo_only_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    result_d   = result_q;
    prod_vld_d = 1'b0;
    prod_idx_d = prod_idx_q;
    in_ready   = 1'b0;

    // Partial issued last cycle lands in the accumulator this cycle.
    if (prod_vld_q) begin
      acc_d = acc_q + prod_shifted;
    end

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_mag_d   = sa ? (~in_a + 1'b1) : in_a;
          b_mag_d   = sb ? (~in_b + 1'b1) : in_b;
          neg_d     = sa ^ sb;
          lo_only_d = in_lo_only;
          idx_d     = P_LL;
          acc_d     = '0;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        prod_vld_d = 1'b1;
        prod_idx_d = idx_q;
        if (idx_q == last_idx) begin
          state_d = ST_DRAIN;
        end else begin
          idx_d = idx_q + 2'd1;
        end
      end
      ST_DRAIN: begin
        state_d = ST_FIX;
      end
      ST_FIX: begin
        result_d = neg_q ? (~acc_q + 1'b1) : acc_q;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      a_mag_q    <= '0;
      b_mag_q    <= '0;
      neg_q      <= 1'b0;
      lo_only_q  <= 1'b0;
      idx_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      prod_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      a_mag_q    <= a_mag_d;
      b_mag_q    <= b_mag_d;
      neg_q      <= neg_d;
      lo_only_q  <= lo_only_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
      prod_idx_q <= prod_idx_d;
    end
  end

  assign out_valid  = (state_q == ST_DONE);
  assign out_result = result_q;

endmodule

// File: tb/tb_nios2_mul_seq_ctrl.sv
// Bench for nios2_mul_seq_ctrl: directed products, lo_only skip, backpressure,
// back-to-back throughput, mid-sequence reset, and a LO_SKIP=0 instance.
// Latency is counted with the accept cycle as cycle 1, so out_valid is first
// sampled high after the 6th edge past accept for 4 partials (latency 7).

module tb_nios2_mul_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] in_a, in_b;
  logic        in_sign_a, in_sign_b, in_lo_only;
  logic        out_valid, out_ready;
  logic [63:0] out_result;

  logic        in_valid_0, in_ready_0;
  logic [31:0] in_a_0, in_b_0;
  logic        in_lo_only_0;
  logic        out_valid_0, out_ready_0;
  logic [63:0] out_result_0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] val;
    logic [63:0] mask;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb0_q[$];

  nios2_mul_seq_ctrl #(.WIDTH(32), .LO_SKIP(1'b1)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_sign_a  (in_sign_a),
    .in_sign_b  (in_sign_b),
    .in_lo_only (in_lo_only),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  nios2_mul_seq_ctrl #(.WIDTH(32), .LO_SKIP(1'b0)) dut0 (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid_0),
    .in_ready   (in_ready_0),
    .in_a       (in_a_0),
    .in_b       (in_b_0),
    .in_sign_a  (1'b0),
    .in_sign_b  (1'b0),
    .in_lo_only (in_lo_only_0),
    .out_valid  (out_valid_0),
    .out_ready  (out_ready_0),
    .out_result (out_result_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference product via sign/zero extension to 64 bits.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sa, input logic sb);
    logic signed [63:0] ea, eb;
    ea = sa ? $signed({{32{a[31]}}, a}) : $signed({32'h0, a});
    eb = sb ? $signed({{32{b[31]}}, b}) : $signed({32'h0, b});
    return 64'(ea * eb);
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sa,
                        input logic sb, input logic lo, input logic [63:0] expv,
                        input int exp_lat, input bit early);
    exp_t e;
    exp_t got;
    int n;
    in_a = a; in_b = b; in_sign_a = sa; in_sign_b = sb; in_lo_only = lo;
    in_valid = 1'b1; out_ready = early;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL op_accept in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    e.val = expv;
    e.mask = lo ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
    sb_q.push_back(e);
    #1; in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n + 1 != exp_lat) begin
      errors++; $display("FAIL op_latency got %0d required %0d", n + 1, exp_lat);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL op_busy_in_ready got %b required 0", in_ready);
    end
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      checks++;
      if ((out_result & got.mask) !== (got.val & got.mask)) begin
        errors++;
        $display("FAIL op_result a=%h b=%h got %h required %h mask %h",
                 a, b, out_result, got.val, got.mask);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL op_handshake out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 64'h0) begin
      errors++;
      $display("FAIL reset_state in_ready=%b out_valid=%b out_result=%h required 1/0/0",
               in_ready, out_valid, out_result);
    end
    checks++;
    if (in_ready_0 !== 1'b1 || out_valid_0 !== 1'b0 || out_result_0 !== 64'h0) begin
      errors++;
      $display("FAIL reset_state_noskip in_ready=%b out_valid=%b out_result=%h required 1/0/0",
               in_ready_0, out_valid_0, out_result_0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_unsigned();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001, 7, 1'b0);
    run_op(32'h0000_0000, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 64'h0, 7, 1'b0);
  endtask

  task automatic test_signed();
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 64'h0000_0000_0000_0001, 7, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 64'h4000_0000_0000_0000, 7, 1'b0);
    run_op(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0002, 7, 1'b0);
    run_op(32'h0000_0007, 32'hFFFF_FFFD, 1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFEB, 7, 1'b1);
  endtask

  task automatic test_lo_only();
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 1'b1, 64'h0B00_EA4E_242D_2080, 6, 1'b0);
    run_op(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 6, 1'b0);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic sa, sb;
    for (int i = 0; i < 8; i++) begin
      a = $urandom; b = $urandom;
      sa = 1'($urandom_range(0, 1)); sb = 1'($urandom_range(0, 1));
      run_op(a, b, sa, sb, 1'b0, model(a, b, sa, sb), 7, i[0]);
    end
  endtask

  task automatic test_no_skip();
    exp_t e;
    exp_t got;
    int n;
    in_a_0 = 32'h1234_5678; in_b_0 = 32'h9ABC_DEF0; in_lo_only_0 = 1'b1;
    in_valid_0 = 1'b1; out_ready_0 = 1'b0;
    checks++;
    if (in_ready_0 !== 1'b1) begin
      errors++; $display("FAIL noskip_ready got %b required 1", in_ready_0);
    end
    @(posedge clk);
    e.val = 64'h0B00_EA4E_242D_2080; e.mask = 64'hFFFF_FFFF_FFFF_FFFF;
    sb0_q.push_back(e);
    #1; in_valid_0 = 1'b0;
    n = 0;
    while (out_valid_0 !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n + 1 != 7) begin
      errors++; $display("FAIL noskip_latency got %0d required 7", n + 1);
    end
    got = sb0_q.pop_front();
    checks++;
    if (out_result_0 !== got.val) begin
      errors++; $display("FAIL noskip_result got %h required %h", out_result_0, got.val);
    end
    out_ready_0 = 1'b1;
    @(posedge clk); #1;
    out_ready_0 = 1'b0;
  endtask

  task automatic test_backpressure();
    exp_t e;
    exp_t got;
    logic [63:0] held;
    int n;
    in_a = 32'h0001_0003; in_b = 32'h0002_0005; in_sign_a = 1'b0; in_sign_b = 1'b0;
    in_lo_only = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    e.val = model(32'h0001_0003, 32'h0002_0005, 1'b0, 1'b0); e.mask = '1;
    sb_q.push_back(e);
    #1;
    // Second request held from here on; it must wait until the first is consumed.
    in_a = 32'hDEAD_BEEF; in_b = 32'hFFFF_FFF0; in_sign_a = 1'b1; in_sign_b = 1'b1;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    held = out_result;
    got = sb_q.pop_front();
    checks++;
    if (held !== got.val) begin
      errors++; $display("FAIL bp_first_result got %h required %h", held, got.val);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_result !== held || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d out_valid=%b in_ready=%b result=%h required 1/0/%h",
                 c, out_valid, in_ready, out_result, held);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    e.val = model(32'hDEAD_BEEF, 32'hFFFF_FFF0, 1'b1, 1'b1);
    sb_q.push_back(e);
    #1; in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    got = sb_q.pop_front();
    checks++;
    if (out_result !== got.val || n + 1 != 7) begin
      errors++;
      $display("FAIL bp_second got %h lat %0d required %h lat 7", out_result, n + 1, got.val);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_t got;
    int n;
    bit seen;
    for (int i = 0; i < 3; i++) begin
      in_a = $urandom; in_b = $urandom; in_sign_a = i[0]; in_sign_b = 1'b0;
      in_lo_only = (i == 2); in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk);
      e.val = model(in_a, in_b, in_sign_a, 1'b0);
      e.mask = in_lo_only ? 64'h0000_0000_FFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
      sb_q.push_back(e);
      #1;
      n = 0; seen = 1'b0;
      while (in_ready !== 1'b1 && n < 20) begin
        @(posedge clk); #1; n++;
        if (out_valid === 1'b1 && sb_q.size() > 0) begin
          seen = 1'b1;
          got = sb_q.pop_front();
          checks++;
          if ((out_result & got.mask) !== (got.val & got.mask)) begin
            errors++;
            $display("FAIL b2b_result op %0d got %h required %h", i, out_result, got.val);
          end
        end
      end
      checks++;
      if (!seen) begin
        errors++; $display("FAIL b2b_output op %0d out_valid=0 required 1", i);
      end
      checks++;
      if (n + 1 != ((i == 2) ? 7 : 8)) begin
        errors++;
        $display("FAIL b2b_period op %0d got %0d required %0d", i, n + 1, (i == 2) ? 7 : 8);
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    in_a = 32'h1111_1111; in_b = 32'h2222_2222; in_sign_a = 1'b0; in_sign_b = 1'b0;
    in_lo_only = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    // Second ISSUE cycle: reset here drops the operation.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 64'h0) begin
      errors++;
      $display("FAIL midreset_state in_ready=%b out_valid=%b result=%h required 1/0/0",
               in_ready, out_valid, out_result);
    end
    run_op(32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 64'd15, 7, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_sign_a = 1'b0; in_sign_b = 1'b0;
    in_lo_only = 1'b0; out_ready = 1'b0;
    in_valid_0 = 1'b0; in_a_0 = '0; in_b_0 = '0; in_lo_only_0 = 1'b0; out_ready_0 = 1'b0;
    test_reset();
    test_unsigned();
    test_signed();
    test_lo_only();
    test_no_skip();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_mid_reset();
    checks++;
    if (sb_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_empty left %0d required 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout reached required finish");
    $fatal(1, "timeout");
  end

endmodule
